// File: rtl/csr_pkg.sv
// Shared definitions for the CSR bus initiator: Zicsr funct3 codes, FSM states, CSR addresses.
// Used by csr_op_decode and csr_access_unit (optional read-only check: CSR_ACCESS_RO_CHECK_EN).
package csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } csr_state_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;

    // Addresses 0xC00-0xFFF are the read-only CSR space.
    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_op_decode.sv
// Combinational Zicsr operation decode: turns funct3 and operands into the
// write-needed flag and the set/clear masks driven during the WRITE cycle.
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  zimm_i,
    input  logic        rs1_zero_i,
    output logic        write_needed_o,
    output logic        bad_funct3_o,
    output logic [31:0] set_o,
    output logic [31:0] clear_o
);

    logic [31:0] w_op;

    assign w_op = funct3_i[2] ? {27'b0, zimm_i} : rs1_data_i;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        write_needed_o = 1'b0;
        bad_funct3_o   = 1'b0;
        set_o          = '0;
        clear_o        = '0;
        case (funct3_i)
            CSR_RW, CSR_RWI: begin
                write_needed_o = 1'b1;
                set_o          = w_op;
                clear_o        = ~w_op;
            end
            CSR_RS, CSR_RSI: begin
                write_needed_o = !rs1_zero_i;
                set_o          = w_op;
            end
            CSR_RC, CSR_RCI: begin
                write_needed_o = !rs1_zero_i;
                clear_o        = w_op;
            end
            default: bad_funct3_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR bus initiator: runs a read cycle and an optional write cycle for one Zicsr instruction.
// Define CSR_ACCESS_RO_CHECK_EN to trap writes to the read-only range 0xC00-0xFFF.
module csr_access_unit
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  zimm_i,
    input  logic        rs1_zero_i,
    input  logic        flush_i,
    output logic        csr_en_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_set_o,
    output logic [31:0] csr_clear_o,
    input  logic        csr_ack_i,
    input  logic [31:0] csr_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_illegal_o
);

    csr_state_e  r_state;
    logic [11:0] r_addr;
    logic [31:0] r_set;
    logic [31:0] r_clear;
    logic        r_write_needed;
    logic [31:0] r_rdata;
    logic        r_illegal;

    logic        w_write_needed;
    logic        w_bad_funct3;
    logic [31:0] w_set;
    logic [31:0] w_clear;
    logic        w_ro_violation;
    logic        w_read_illegal;

    // Decode at accept time so only the resulting masks need to be held.
    csr_op_decode u_op_decode (
        .funct3_i       (funct3_i),
        .rs1_data_i     (rs1_data_i),
        .zimm_i         (zimm_i),
        .rs1_zero_i     (rs1_zero_i),
        .write_needed_o (w_write_needed),
        .bad_funct3_o   (w_bad_funct3),
        .set_o          (w_set),
        .clear_o        (w_clear)
    );

`ifdef CSR_ACCESS_RO_CHECK_EN
    assign w_ro_violation = is_read_only(r_addr) && r_write_needed;
`else
    assign w_ro_violation = 1'b0;
`endif

    assign w_read_illegal = !csr_ack_i || w_ro_violation;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_set          <= '0;
            r_clear        <= '0;
            r_write_needed <= 1'b0;
            r_rdata        <= '0;
            r_illegal      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        r_addr         <= csr_addr_i;
                        r_set          <= w_set;
                        r_clear        <= w_clear;
                        r_write_needed <= w_write_needed;
                        if (w_bad_funct3) begin
                            r_rdata   <= '0;
                            r_illegal <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rdata   <= csr_rdata_i;
                        r_illegal <= w_read_illegal;
                        r_state   <= (r_write_needed && !w_read_illegal) ? ST_WRITE : ST_DONE;
                    end
                end
                // The write is committed once issued, so flush is not sampled here.
                ST_WRITE: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus and handshake outputs depend on state only; reset drops them at once.
    assign req_ready_o    = (r_state == ST_IDLE);
    assign csr_en_o       = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign csr_addr_o     = csr_en_o ? r_addr : '0;
    assign csr_set_o      = (r_state == ST_WRITE) ? r_set : '0;
    assign csr_clear_o    = (r_state == ST_WRITE) ? r_clear : '0;
    assign resp_valid_o   = (r_state == ST_DONE);
    assign resp_rdata_o   = r_rdata;
    assign resp_illegal_o = r_illegal;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR register bus. Accepts one decoded Zicsr instruction (CSRRW/S/C and immediate forms) from the execute stage, runs a read cycle and an optional write cycle on the shared `en/addr/set/clear` bus that the per-register CSR blocks respond to, and returns the old CSR value plus an illegal-instruction flag to the pipeline. It sits between the execute stage and the CSR register bank.

## Interface
- No parameters.
- `clk_i  in  1`  clock.
- `rst_ni  in  1`  reset; asynchronous, active-low.
- `req_valid_i  in  1`  CSR instruction present.
- `req_ready_o  out  1`  unit idle, can accept a request.
- `funct3_i  in  3`  Zicsr funct3.
- `csr_addr_i  in  12`  CSR address.
- `rs1_data_i  in  32`  register operand.
- `zimm_i  in  5`  immediate operand, zero-extended.
- `rs1_zero_i  in  1`  rs1/zimm field is 0.
- `flush_i  in  1`  pipeline flush.
- `csr_en_o  out  1`  bus enable.
- `csr_addr_o  out  12`  bus address.
- `csr_set_o  out  32`  bits to set.
- `csr_clear_o  out  32`  bits to clear.
- `csr_ack_i  in  1`  OR of all register acks.
- `csr_rdata_i  in  32`  OR of the selected register `value_o`s; zero when no register acks.
- `resp_valid_o  out  1`  one-cycle response strobe.
- `resp_rdata_o  out  32`  CSR value before the write.
- `resp_illegal_o  out  1`  raise illegal-instruction trap.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `req_ready_o=1`; bus idle.
  - On `req_valid_i`, latch `funct3`, address, operand and `rs1_zero`.
  - Go to READ, or to DONE with illegal=1 when funct3 is 000 or 100.
- READ:
  - Drive `csr_en_o=1`, latched address, `set=clear=0`.
  - Capture `csr_rdata_i` into `resp_rdata_o` and `csr_ack_i`.
  - No ack gives illegal; go to DONE.
  - Write needed when funct3 is RW/RWI, or when S/C/SI/CI with `rs1_zero=0`.
  - Write needed and not illegal: go to WRITE. Otherwise go to DONE.
- WRITE:
  - Drive `csr_en_o=1`, same address. Operand `op` is `rs1_data` or `{27'b0,zimm}`.
  - RW: `set=op`, `clear=~op`.
  - RS: `set=op`, `clear=0`.
  - RC: `set=0`, `clear=op`.
  - Go to DONE.
- DONE: `resp_valid_o=1` for one cycle, then IDLE.
- `resp_rdata_o` and `resp_illegal_o` hold their values until the next accept.
- Read-only check: addr[11:10]==2'b11 with a write needed gives illegal. No WRITE cycle is issued. See Configuration.
- Flush:
  - `flush_i` in READ: return to IDLE, no response.
  - `flush_i` in WRITE or DONE is ignored, because the write is committed.
  - `flush_i` in IDLE blocks acceptance that cycle.

## Timing
- Request accepted at edge 0.
- READ occupies cycle 1.
- Without a write: DONE in cycle 2.
- With a write: WRITE in cycle 2, DONE in cycle 3.
- Throughput: one request per 3–4 cycles. `req_ready_o` is low from cycle 1 through DONE.
- All outputs are registered or decoded from state only. There is no combinational path from `csr_ack_i` or `csr_rdata_i` to bus outputs.
- Reset (asynchronous, any state): IDLE. `req_ready_o=1`; all other outputs 0, including `resp_rdata_o=0`.
- Reset asserted mid-WRITE: the bus deasserts immediately. The register-side write is not guaranteed.

## Configuration
- `CSR_ACCESS_RO_CHECK_EN` defined: the read-only address check above is active.
- `CSR_ACCESS_RO_CHECK_EN` undefined:
  - No read-only check; writes to 0xC00–0xFFF are issued.
  - Only a missing ack makes an access illegal.

## Structure
- Package `csr_pkg` holds:
  - funct3 localparams: `CSR_RW=3'b001`, `RS=010`, `RC=011`, `RWI=101`, `RSI=110`, `RCI=111`.
  - FSM state enum.
  - CSR address constants, e.g. `CSR_MSTATUS=12'h300`.
- Sub-module `csr_op_decode`, purely combinational:
  - Input: funct3, operands, rs1_zero.
  - Output: `write_needed`, `bad_funct3`, `set`, `clear`.

## Test plan
- mstatus at 0x300 resets to 0x00001800.
- CSRRSI 0x300, zimm=8:
  - READ in cycle 1, WRITE `set=0x8, clear=0` in cycle 2.
  - Response in cycle 3: rdata=0x00001800, illegal=0.
  - A follow-up CSRRS x0 reads 0x00001808.
- CSRRC 0x300, rs1=0x88, after MIE and MPIE are set:
  - WRITE `set=0, clear=0x88`.
  - Response rdata=0x00001888; the next read gives 0x00001800.
- CSRRS 0x300 with `rs1_zero=1`: no WRITE cycle, response in cycle 2, `csr_en_o` high in cycle 1 only.
- CSRRW 0x7C0, no ack: illegal=1, rdata=0, no WRITE cycle.
- CSRRW 0xC00 with ack:
  - With the macro: illegal=1, no WRITE.
  - Without the macro: WRITE issued, illegal=0.
- `rst_ni` low during WRITE: the bus drops in the same cycle, the unit returns to IDLE, `req_ready_o=1`.
- `flush_i` in READ: no `resp_valid_o` is produced.
